// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// externally registered adder. Each accepted operation walks through
// IDLE -> ISSUE -> CAPTURE -> RESP and returns its sum with the requester id.
// Optional feature: define ADDER_ARB_OVF_CNT_EN to count carry-out events
// on ovf_cnt (saturating at 255); otherwise ovf_cnt is tied to zero.
module adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]     req_a,
   input  logic [NUM_REQ*DATA_W-1:0]     req_b,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_W-1:0]             add_a,
   output logic [DATA_W-1:0]             add_b,
   input  logic [DATA_W:0]               add_c,
   output logic                          rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
   output logic [DATA_W:0]               rsp_sum,
   input  logic                          rsp_ready,
   output logic                          busy,
   output logic [7:0]                    ovf_cnt
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [ID_W-1:0]     r_lastGrant;
   logic [ID_W-1:0]     r_id;
   logic [ID_W-1:0]     w_winner;
   logic                w_found;
   logic                w_transfer;
   logic [DATA_W-1:0]   r_addA;
   logic [DATA_W-1:0]   r_addB;
   logic [DATA_W:0]     r_sum;

   // Round-robin search starting just after the last granted requester,
   // wrapping around so every requester gets a turn.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && req_valid[(int'(r_lastGrant) + k) % NUM_REQ]) begin
            w_found  = 1'b1;
            w_winner = ID_W'((int'(r_lastGrant) + k) % NUM_REQ);
         end
      end
   end

   // A transfer only happens in IDLE outside reset; req_ready mirrors it one-hot.
   always_comb begin
      w_transfer = (r_state == IDLE) && !rst && w_found;
      req_ready  = '0;
      if (w_transfer) begin
         req_ready = NUM_REQ'(1) << w_winner;
      end
   end

   // Next-state logic: ISSUE and CAPTURE are fixed one-cycle steps, RESP
   // waits for the consumer.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_transfer) w_nextState = ISSUE;
         ISSUE:   w_nextState = CAPTURE;
         CAPTURE: w_nextState = RESP;
         RESP:    if (rsp_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State register; reset abandons whatever operation is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Latch the winner's operands and id on transfer, and grab the adder
   // result during CAPTURE since the adder has its own output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastGrant <= ID_W'(NUM_REQ - 1);
         r_id        <= '0;
         r_addA      <= '0;
         r_addB      <= '0;
         r_sum       <= '0;
      end else begin
         if (w_transfer) begin
            r_lastGrant <= w_winner;
            r_id        <= w_winner;
            r_addA      <= req_a[w_winner*DATA_W +: DATA_W];
            r_addB      <= req_b[w_winner*DATA_W +: DATA_W];
         end
         if (r_state == CAPTURE) begin
            r_sum <= add_c;
         end
      end
   end

   assign add_a     = r_addA;
   assign add_b     = r_addB;
   assign rsp_valid = (r_state == RESP);
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign busy      = (r_state != IDLE);

`ifdef ADDER_ARB_OVF_CNT_EN
   logic [7:0] r_ovfCnt;

   // Count CAPTURE cycles whose sum carried out, holding at 255.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovfCnt <= 8'd0;
      end else if ((r_state == CAPTURE) && add_c[DATA_W] && (r_ovfCnt != 8'hFF)) begin
         r_ovfCnt <= r_ovfCnt + 8'd1;
      end
   end

   assign ovf_cnt = r_ovfCnt;
`else
   assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_adder_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 4;
   localparam int ID_W    = 2;
`ifdef ADDER_ARB_OVF_CNT_EN
   localparam int OVF_EN  = 1;
`else
   localparam int OVF_EN  = 0;
`endif

   logic                       clk;
   logic                       rst;
   logic [NUM_REQ-1:0]         reqValid;
   logic [NUM_REQ*DATA_W-1:0]  reqA;
   logic [NUM_REQ*DATA_W-1:0]  reqB;
   logic [NUM_REQ-1:0]         reqReady;
   logic [DATA_W-1:0]          addA;
   logic [DATA_W-1:0]          addB;
   logic [DATA_W:0]            addC;
   logic                       rspValid;
   logic [ID_W-1:0]            rspId;
   logic [DATA_W:0]            rspSum;
   logic                       rspReady;
   logic                       busy;
   logic [7:0]                 ovfCnt;

   adder_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_a     (reqA),
      .req_b     (reqB),
      .req_ready (reqReady),
      .add_a     (addA),
      .add_b     (addB),
      .add_c     (addC),
      .rsp_valid (rspValid),
      .rsp_id    (rspId),
      .rsp_sum   (rspSum),
      .rsp_ready (rspReady),
      .busy      (busy),
      .ovf_cnt   (ovfCnt)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared adder with its own output register.
   always @(posedge clk) begin
      addC <= {1'b0, addA} + {1'b0, addB};
   end

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DATA_W-1:0] a,
                                input logic [NUM_REQ*DATA_W-1:0] b, input logic rr);
      reqValid = v;
      reqA     = a;
      reqB     = b;
      rspReady = rr;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus('0, '0, '0, 1'b1);
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   // Round-robin rule: first valid requester after the last grant.
   function automatic int rrPick(input logic [NUM_REQ-1:0] v, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // Transaction model: mAge counts cycles since the accepted transfer
   // (-1 when nothing is in flight); the response shows up 3 cycles later.
   int mLast = NUM_REQ - 1;
   int mAge  = -1;
   int mId   = 0;
   int mSum  = 0;
   int mPend = 0;
   int mA    = 0;
   int mB    = 0;
   int mOvf  = 0;
   int cyc   = 0;
   int grantIdx[$];
   int grantCyc[$];

   // Compare DUT against the model every cycle, then advance the model using
   // the inputs the DUT will sample at the coming rising edge.
   always @(negedge clk) begin
      int pick;
      int dutIdx;
      logic [NUM_REQ-1:0] expReady;
      cyc++;
      pick = rrPick(reqValid, mLast);
      expReady = '0;
      if (!rst && mAge < 0 && pick >= 0) expReady[pick] = 1'b1;

      checkOutput("model req_ready", reqReady, expReady);
      checkOutput("model busy", busy, (mAge >= 0));
      checkOutput("model rsp_valid", rspValid, (mAge >= 3));
      checkOutput("model rsp_id", rspId, mId);
      checkOutput("model rsp_sum", rspSum, mSum);
      checkOutput("model add_a", addA, mA);
      checkOutput("model add_b", addB, mB);
      checkOutput("model ovf_cnt", ovfCnt, mOvf);

      dutIdx = -1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reqReady[i] && reqValid[i]) dutIdx = i;
      end
      if (dutIdx >= 0) begin
         grantIdx.push_back(dutIdx);
         grantCyc.push_back(cyc);
      end

      if (rst) begin
         mLast = NUM_REQ - 1;
         mAge  = -1;
         mId   = 0;
         mSum  = 0;
         mA    = 0;
         mB    = 0;
         mOvf  = 0;
      end else if (mAge < 0) begin
         if (pick >= 0) begin
            mLast = pick;
            mId   = pick;
            mA    = int'(reqA[pick*DATA_W +: DATA_W]);
            mB    = int'(reqB[pick*DATA_W +: DATA_W]);
            mPend = mA + mB;
            mAge  = 1;
         end
      end else if (mAge < 3) begin
         if (mAge == 2) begin
            mSum = mPend;
            if (OVF_EN == 1 && mPend >= (1 << DATA_W) && mOvf < 255) mOvf++;
         end
         mAge++;
      end else if (rspReady) begin
         mAge = -1;
      end
   end

   // Directed scenarios.
   initial begin
      int startIdx;
      int expOrder[5];
      expOrder = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      applyStimulus('1, '1, '1, 1'b0);
      nextCycle();
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("reset req_ready", reqReady, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset rsp_valid", rspValid, 0);
      checkOutput("reset add_a", addA, 0);

      $display("[TB] single request from requester 2");
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'b0100, 16'h0700, 16'h0900, 1'b1);
      @(negedge clk);
      checkOutput("t1 req_ready", reqReady, 4'b0100);
      nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      @(negedge clk);
      checkOutput("t1 add_a", addA, 7);
      checkOutput("t1 add_b", addB, 9);
      nextCycle();
      @(negedge clk);
      checkOutput("t1 rsp_valid early", rspValid, 0);
      nextCycle();
      @(negedge clk);
      checkOutput("t1 rsp_valid", rspValid, 1);
      checkOutput("t1 rsp_id", rspId, 2);
      checkOutput("t1 rsp_sum", rspSum, 16);
      nextCycle();
      @(negedge clk);
      checkOutput("t1 rsp_valid drop", rspValid, 0);
      checkOutput("t1 busy drop", busy, 0);

      $display("[TB] all requesters valid, round-robin order");
      doReset();
      applyStimulus(4'hF, 16'h4321, 16'h8765, 1'b1);
      startIdx = grantIdx.size();
      repeat (17) nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      repeat (5) nextCycle();
      checkOutput("t2 grant count", grantIdx.size() - startIdx, 5);
      for (int j = 0; j < 5; j++) begin
         if (startIdx + j < grantIdx.size()) begin
            checkOutput("t2 grant order", grantIdx[startIdx + j], expOrder[j]);
            if (j > 0) checkOutput("t2 grant spacing", grantCyc[startIdx + j] - grantCyc[startIdx + j - 1], 4);
         end
      end

      $display("[TB] response held by consumer backpressure");
      applyStimulus(4'b0010, 16'h0030, 16'h0040, 1'b0);
      nextCycle();
      applyStimulus('0, '0, '0, 1'b0);
      nextCycle();
      nextCycle();
      applyStimulus(4'hF, '0, '0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("t3 rsp_valid hold", rspValid, 1);
         checkOutput("t3 rsp_id hold", rspId, 1);
         checkOutput("t3 rsp_sum hold", rspSum, 7);
         checkOutput("t3 req_ready hold", reqReady, 0);
         checkOutput("t3 busy hold", busy, 1);
         nextCycle();
      end
      applyStimulus('0, '0, '0, 1'b1);
      @(negedge clk);
      checkOutput("t3 rsp_valid release", rspValid, 1);
      nextCycle();
      @(negedge clk);
      checkOutput("t3 rsp_valid after", rspValid, 0);
      checkOutput("t3 busy after", busy, 0);

      $display("[TB] reset during CAPTURE");
      doReset();
      applyStimulus(4'b1000, 16'h5000, 16'h6000, 1'b1);
      nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'hF, 16'h4321, 16'h8765, 1'b1);
      @(negedge clk);
      checkOutput("t4 rsp_valid", rspValid, 0);
      checkOutput("t4 busy", busy, 0);
      checkOutput("t4 add_a", addA, 0);
      checkOutput("t4 add_b", addB, 0);
      checkOutput("t4 first grant", reqReady, 4'b0001);
      nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("t4 rsp_valid", rspValid, 1);
      checkOutput("t4 rsp_id", rspId, 0);
      checkOutput("t4 rsp_sum", rspSum, 6);
      nextCycle();
      nextCycle();

      $display("[TB] carry-out counting");
      doReset();
      applyStimulus(4'b0001, 16'h000F, 16'h000F, 1'b1);
      nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("t5 rsp_sum", rspSum, 30);
      checkOutput("t5 ovf_cnt one", ovfCnt, OVF_EN);
      nextCycle();
      applyStimulus(4'b0001, 16'h000F, 16'h000F, 1'b1);
      repeat (1210) nextCycle();
      applyStimulus('0, '0, '0, 1'b1);
      repeat (5) nextCycle();
      @(negedge clk);
      checkOutput("t5 ovf_cnt saturate", ovfCnt, OVF_EN * 255);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
